rom_port_arbiter: RTL and testbench

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

---
 rtl/rom_port_arbiter_pkg.sv | 15 +
 rtl/rom_port_arbiter_rr_picker.sv | 33 +++
 rtl/rom_port_arbiter.sv | 99 +++++++++
 tb/tb_rom_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// Shared definitions for the program-ROM port arbiter: FSM encodings and
// sizing constants.
package rom_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } arb_state_e;

  localparam int ARB_NUM_PORTS   = 4;
  localparam int ARB_MAX_LATENCY = 7;
  localparam int WAIT_CNT_W      = $clog2(ARB_MAX_LATENCY + 1);

endpackage

// File: rtl/rom_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr,
// wrapping modulo NUM_PORTS.
module rr_picker
  import rom_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = ARB_NUM_PORTS,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:0] sel,
  output logic [IDX_W-1:0]     index
);

  logic w_found;
  int   w_p;

  always_comb begin
    sel     = '0;
    index   = '0;
    w_found = 1'b0;
    w_p     = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_p = (int'(rr_ptr) + k) % NUM_PORTS;
      if (!w_found && req[w_p]) begin
        w_found  = 1'b1;
        sel[w_p] = 1'b1;
        index    = IDX_W'(w_p);
      end
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one program ROM among NUM_PORTS fetch ports;
// one word per ROM_LATENCY+3 cycles.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = ARB_NUM_PORTS,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ROM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_in,
  output logic [DATA_W-1:0]           rdata,
  output logic [NUM_PORTS-1:0]        valid,
  output logic [NUM_PORTS-1:0]        grant,
  output logic                        busy,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [DATA_W-1:0]           rom_data
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  // rom_addr is itself registered, so data is captured one cycle past the
  // ROM's own latency.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(ROM_LATENCY);

  arb_state_e              r_state, w_state_nxt;
  logic [NUM_PORTS-1:0]    r_grant, r_valid;
  logic [DATA_W-1:0]       r_rdata;
  logic [ADDR_W-1:0]       r_rom_addr;
  logic [IDX_W-1:0]        r_rr_ptr, r_idx;
  logic [WAIT_CNT_W-1:0]   r_wait_cnt;
  logic [NUM_PORTS-1:0]    w_sel;
  logic [IDX_W-1:0]        w_idx;

  rr_picker #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .sel    (w_sel),
    .index  (w_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (|req) w_state_nxt = ST_WAIT;
      ST_WAIT:    if (r_wait_cnt == '0) w_state_nxt = ST_RESPOND;
      ST_RESPOND: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_valid    <= '0;
      r_rdata    <= '0;
      r_rom_addr <= '0;
      r_rr_ptr   <= '0;
      r_idx      <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_grant    <= w_sel;
            r_idx      <= w_idx;
            r_rom_addr <= addr_in[w_idx*ADDR_W +: ADDR_W];
            r_wait_cnt <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_rdata <= rom_data;
            r_valid <= r_grant;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        ST_RESPOND: begin
          r_valid  <= '0;
          r_grant  <= '0;
          r_rr_ptr <= (int'(r_idx) == NUM_PORTS - 1) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rdata    = r_rdata;
  assign valid    = r_valid;
  assign grant    = r_grant;
  assign busy     = (r_state != ST_IDLE);
  assign rom_addr = r_rom_addr;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench: directed fetches on a latency-1 arbiter plus a latency-3
// instance for the timing/busy window.
`timescale 1ns/1ps
module tb_rom_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req1, req3;
  logic [127:0] addr1_in, addr3_in;
  logic [31:0]  rdata1, rdata3, rom_addr1, rom_addr3, rom_data1, rom_data3;
  logic [3:0]   valid1, valid3, grant1, grant3;
  logic         busy1, busy3;

  always #21 clk = ~clk;

  rom_port_arbiter #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .ROM_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst_n), .req(req1), .addr_in(addr1_in), .rdata(rdata1),
    .valid(valid1), .grant(grant1), .busy(busy1), .rom_addr(rom_addr1), .rom_data(rom_data1));

  rom_port_arbiter #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .ROM_LATENCY(3)) dut3 (
    .clk(clk), .reset(rst_n), .req(req3), .addr_in(addr3_in), .rdata(rdata3),
    .valid(valid3), .grant(grant3), .busy(busy3), .rom_addr(rom_addr3), .rom_data(rom_data3));

  function automatic logic [31:0] romf(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  // ROM models: registered pipelines of depth ROM_LATENCY.
  logic [31:0] p1;
  logic [31:0] q0, q1, q2;
  always @(posedge clk) begin
    p1 <= romf(rom_addr1);
    q0 <= romf(rom_addr3);
    q1 <= q0;
    q2 <= q1;
  end
  assign rom_data1 = p1;
  assign rom_data3 = q2;

  typedef struct { logic [3:0] v; logic [31:0] d; } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_vcyc = -1;
  bit chk_spacing = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (valid1 !== 4'b0000) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_valid: got valid=%b rdata=%h, want no strobe", valid1, rdata1);
      end else begin
        e = sbq.pop_front();
        if (valid1 !== e.v || rdata1 !== e.d) begin
          n_bad++;
          $display("FAIL valid_data: got valid=%b rdata=%h, want valid=%b rdata=%h",
                   valid1, rdata1, e.v, e.d);
        end
      end
      if (chk_spacing) begin
        if (last_vcyc >= 0) begin
          n_cmp++;
          if (cyc - last_vcyc != 4) begin
            n_bad++;
            $display("FAIL valid_spacing: got %0d cycles, want 4", cyc - last_vcyc);
          end
        end
        last_vcyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] v, input logic [31:0] a);
    exp_t e;
    e.v = v;
    e.d = romf(a);
    sbq.push_back(e);
  endtask

  task automatic set_addr1(input int p, input logic [31:0] a);
    addr1_in[p*32 +: 32] = a;
  endtask

  task automatic wait_valid(input logic [3:0] m);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (((valid1 & m) == 4'b0000) && n < 40);
    if ((valid1 & m) == 4'b0000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid_timeout: got no strobe on mask %b, want one within 40 cycles", m);
    end
  endtask

  initial begin
    int vat, bcnt, vcnt;
    rst_n    = 1'b0;
    req1     = '0;
    req3     = '0;
    addr1_in = '0;
    addr3_in = '0;
    tick(); tick();
    check("rst_valid",    valid1,   0);
    check("rst_grant",    grant1,   0);
    check("rst_busy",     busy1,    0);
    check("rst_rom_addr", rom_addr1, 0);
    check("rst_rdata",    rdata1,   0);
    rst_n = 1'b1;
    tick();

    // Single request on port 2
    req1 = 4'b0100;
    set_addr1(2, 32'h10);
    push(4'b0100, 32'h10);
    tick();
    check("t1_grant",    grant1,    4'b0100);
    check("t1_rom_addr", rom_addr1, 32'h10);
    check("t1_busy",     busy1,     1);
    wait_valid(4'b0100);
    req1 = 4'b0000;
    tick(); tick(); tick();
    check("t1_rdata_hold",     rdata1,    romf(32'h10));
    check("t1_idle_grant",     grant1,    0);
    check("t1_idle_busy",      busy1,     0);
    check("t1_idle_rom_addr",  rom_addr1, 32'h10);

    // Continuous requests on all ports: strict rotation from port 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) set_addr1(p, 32'h100 + p * 4);
    for (int k = 0; k < 12; k++) push(4'b0001 << (k % 4), 32'h100 + (k % 4) * 4);
    chk_spacing = 1'b1;
    last_vcyc   = -1;
    req1 = 4'b1111;
    for (int k = 0; k < 12; k++) wait_valid(4'b1111);
    req1 = 4'b0000;
    chk_spacing = 1'b0;
    tick(); tick();

    // Move rr_ptr to 1, then ports 3 and 0 requesting: 3 wins first
    set_addr1(0, 32'h200);
    set_addr1(3, 32'h230);
    req1 = 4'b0001;
    push(4'b0001, 32'h200);
    wait_valid(4'b0001);
    req1 = 4'b0000;
    tick(); tick();
    req1 = 4'b1001;
    push(4'b1000, 32'h230);
    push(4'b0001, 32'h200);
    wait_valid(4'b1000);
    req1[3] = 1'b0;
    wait_valid(4'b0001);
    req1[0] = 1'b0;
    tick(); tick();

    // Port 1: address changes and req drops while in flight
    set_addr1(1, 32'h40);
    req1 = 4'b0010;
    push(4'b0010, 32'h40);
    tick();
    check("t4_grant", grant1, 4'b0010);
    set_addr1(1, 32'h80);
    req1 = 4'b0000;
    wait_valid(4'b0010);
    tick(); tick();
    check("t4_rdata_hold", rdata1, romf(32'h40));

    // Reset during WAIT aborts; next arbitration starts at port 0
    set_addr1(2, 32'h20);
    req1 = 4'b0100;
    tick();
    check("t5_grant", grant1, 4'b0100);
    tick();
    rst_n = 1'b0;
    req1  = 4'b0000;
    tick();
    check("t5_valid",    valid1,    0);
    check("t5_grant_0",  grant1,    0);
    check("t5_busy",     busy1,     0);
    check("t5_rom_addr", rom_addr1, 0);
    check("t5_rdata",    rdata1,    0);
    rst_n = 1'b1;
    tick();
    set_addr1(0, 32'h30);
    set_addr1(2, 32'h34);
    req1 = 4'b0101;
    push(4'b0001, 32'h30);
    push(4'b0100, 32'h34);
    wait_valid(4'b0001);
    req1[0] = 1'b0;
    wait_valid(4'b0100);
    req1[2] = 1'b0;
    tick(); tick();

    // Latency-3 instance: valid 4 edges after grant, busy for 5 cycles
    addr3_in[31:0] = 32'h55;
    req3 = 4'b0001;
    tick();
    check("t6_grant", grant3, 4'b0001);
    vat  = -1;
    bcnt = busy3 ? 1 : 0;
    vcnt = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (busy3) bcnt++;
      if (valid3 != 4'b0000) begin
        vcnt++;
        vat = n;
        check("t6_valid", valid3, 4'b0001);
        check("t6_rdata", rdata3, romf(32'h55));
        req3 = 4'b0000;
      end
    end
    check("t6_valid_edge", vat,  4);
    check("t6_valid_cnt",  vcnt, 1);
    check("t6_busy_cnt",   bcnt, 5);

    check("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
